dzcpu_useq: RTL and testbench

Microcode sequencer for the dzcpu core: the consumer side of the opcode→flow lookup tables and the micro-op ROM. It accepts a fetched macro-opcode, obtains the flow start index from the opcode LUTs, walks the ROM address (uPC) cycle by cycle and decodes each micro-op's flow-control field. It issues micro-ops to the datapath, requests PC increments and flag updates, handles the 0xCB second-level dispatch, and returns to fetch at end-of-flow.

---
 rtl/dzcpu_useq_pkg.sv | 44 ++++
 rtl/dzcpu_useq_flowdec.sv | 53 +++++
 rtl/dzcpu_useq.sv | 120 ++++++++++++
 tb/tb_dzcpu_useq.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dzcpu_useq_pkg.sv
// Shared definitions for the dzcpu micro-sequencer: opcodes, micro-op field layout,
// flow-control codes and sequencer states.
package dzcpu_useq_pkg;

    localparam int UOP_W_DEF  = 13;
    localparam int ADDR_W_DEF = 8;

    // Micro-op layout: [12:9] flow, [8:4] op, [3:0] operand
    localparam int FLOW_MSB = 12;
    localparam int FLOW_LSB = 9;
    localparam int OP_MSB   = 8;
    localparam int OP_LSB   = 4;
    localparam int ARG_MSB  = 3;
    localparam int ARG_LSB  = 0;

    // Macro-opcodes
    localparam logic [7:0] MOP_NOP    = 8'h00;
    localparam logic [7:0] MOP_JRNZ_N = 8'h20;
    localparam logic [7:0] MOP_JRZ_N  = 8'h28;
    localparam logic [7:0] MOP_LDSPNN = 8'h31;
    localparam logic [7:0] MOP_BIT7H  = 8'h7C;
    localparam logic [7:0] MOP_CB     = 8'hCB;

    // Flow-control codes; any other value behaves as FLOW_OP
    localparam logic [3:0] FLOW_OP           = 4'h0;
    localparam logic [3:0] FLOW_INC          = 4'h1;
    localparam logic [3:0] FLOW_EOF          = 4'h2;
    localparam logic [3:0] FLOW_INC_EOF      = 4'h3;
    localparam logic [3:0] FLOW_EOF_FU       = 4'h4;
    localparam logic [3:0] FLOW_INC_EOF_FU   = 4'h5;
    localparam logic [3:0] FLOW_INC_EOF_Z    = 4'h6;
    localparam logic [3:0] FLOW_INC_EOF_NZ   = 4'h7;
    localparam logic [3:0] FLOW_UPDATE_FLAGS = 4'h8;
    localparam logic [3:0] FLOW_NOP          = 4'h9;

    localparam logic [4:0] UOP_JCB = 5'h1F;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXEC    = 2'd1,
        ST_CBFETCH = 2'd2
    } useq_state_t;

endpackage

// File: rtl/dzcpu_useq_flowdec.sv
// Combinational decode of a micro-op flow field into sequencing side-effect flags.
// Zero latency; no state, no backpressure.
module dzcpu_useq_flowdec
    import dzcpu_useq_pkg::*;
(
    input  logic [3:0] flow,
    output logic       pc_inc,
    output logic       flag_upd,
    output logic       eof,
    output logic       abort_on_z,
    output logic       abort_on_nz,
    output logic       no_exec
);

    always_comb begin
        pc_inc      = 1'b0;
        flag_upd    = 1'b0;
        eof         = 1'b0;
        abort_on_z  = 1'b0;
        abort_on_nz = 1'b0;
        no_exec     = 1'b0;
        case (flow)
            FLOW_INC:          pc_inc = 1'b1;
            FLOW_EOF:          eof = 1'b1;
            FLOW_INC_EOF: begin
                pc_inc = 1'b1;
                eof    = 1'b1;
            end
            FLOW_EOF_FU: begin
                flag_upd = 1'b1;
                eof      = 1'b1;
            end
            FLOW_INC_EOF_FU: begin
                pc_inc   = 1'b1;
                flag_upd = 1'b1;
                eof      = 1'b1;
            end
            // Conditional exits: the PC advances whether or not the flow aborts
            FLOW_INC_EOF_Z: begin
                pc_inc     = 1'b1;
                abort_on_z = 1'b1;
            end
            FLOW_INC_EOF_NZ: begin
                pc_inc      = 1'b1;
                abort_on_nz = 1'b1;
            end
            FLOW_UPDATE_FLAGS: flag_upd = 1'b1;
            FLOW_NOP:          no_exec = 1'b1;
            default:           ;
        endcase
    end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu microcode sequencer: opcode accepted at edge N issues its first micro-op in N+1; iStall
// freezes state/uPC and masks all side effects. DZCPU_USEQ_WDOG_EN adds a 64-issue watchdog.
module dzcpu_useq
    import dzcpu_useq_pkg::*;
#(
    parameter int UOP_W  = UOP_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [7:0]        iMop,
    input  logic              iMopValid,
    input  logic [ADDR_W-1:0] iFlowIdx,
    input  logic [ADDR_W-1:0] iCbFlowIdx,
    input  logic [UOP_W-1:0]  iUop,
    input  logic              iZFlag,
    input  logic              iStall,
    output logic [7:0]        oLutMop,
    output logic [ADDR_W-1:0] oUopAddr,
    output logic [UOP_W-1:0]  oUop,
    output logic              oUopValid,
    output logic              oPcInc,
    output logic              oFlagUpdate,
    output logic              oMopDone,
    output logic              oFetchReady,
    output logic              oError
);

    useq_state_t       state, state_nxt;
    logic [ADDR_W-1:0] upc, upc_nxt;

    logic pc_inc, flag_upd, eof, abort_on_z, abort_on_nz, no_exec;
    logic run, skip, issue, done, is_jcb, wdog_trip;

    dzcpu_useq_flowdec u_flowdec (
        .flow        (iUop[FLOW_MSB:FLOW_LSB]),
        .pc_inc      (pc_inc),
        .flag_upd    (flag_upd),
        .eof         (eof),
        .abort_on_z  (abort_on_z),
        .abort_on_nz (abort_on_nz),
        .no_exec     (no_exec)
    );

    assign run    = (state == ST_EXEC) && !iStall;
    assign skip   = (abort_on_z && iZFlag) || (abort_on_nz && !iZFlag);
    assign issue  = run && !no_exec && !skip;
    assign is_jcb = (iUop[OP_MSB:OP_LSB] == UOP_JCB);

`ifdef DZCPU_USEQ_WDOG_EN
    logic [5:0] wdog_cnt;

    // Counts issued micro-ops of the current macro-op, including its CB half
    always_ff @(posedge iClock) begin
        if (iReset || state == ST_FETCH) begin
            wdog_cnt <= '0;
        end else if (issue) begin
            wdog_cnt <= wdog_cnt + 6'd1;
        end
    end

    assign wdog_trip = issue && (wdog_cnt == 6'd63) && !eof && !skip;
`else
    assign wdog_trip = 1'b0;
`endif

    assign done = run && (eof || skip || wdog_trip);

    always_comb begin
        state_nxt = state;
        upc_nxt   = upc;
        case (state)
            ST_FETCH: begin
                if (iMopValid && !iStall) begin
                    upc_nxt   = iFlowIdx;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (run) begin
                    if (done) begin
                        state_nxt = ST_FETCH;
                    end else if (is_jcb) begin
                        state_nxt = ST_CBFETCH;
                    end else begin
                        upc_nxt = upc + ADDR_W'(1);
                    end
                end
            end
            ST_CBFETCH: begin
                if (iMopValid && !iStall) begin
                    upc_nxt   = iCbFlowIdx;
                    state_nxt = ST_EXEC;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state <= ST_FETCH;
            upc   <= '0;
        end else begin
            state <= state_nxt;
            upc   <= upc_nxt;
        end
    end

    assign oLutMop     = iMop;
    assign oUopAddr    = upc;
    assign oUop        = iUop;
    assign oUopValid   = issue;
    assign oPcInc      = run && pc_inc;
    assign oFlagUpdate = run && flag_upd;
    assign oMopDone    = done;
    assign oFetchReady = (state == ST_FETCH);
    assign oError      = wdog_trip;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Bench for dzcpu_useq: a flow-walking model over the bench ROM/LUTs expands each macro-op
// into a per-cycle expectation trace that is replayed against the DUT.
module tb_dzcpu_useq;
    import dzcpu_useq_pkg::*;

`ifdef DZCPU_USEQ_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic        iClock = 1'b0;
    logic        iReset = 1'b1;
    logic [7:0]  iMop = 8'h00;
    logic        iMopValid = 1'b0;
    logic [7:0]  iFlowIdx, iCbFlowIdx;
    logic [12:0] iUop;
    logic        iZFlag = 1'b0;
    logic        iStall = 1'b0;
    logic [7:0]  oLutMop, oUopAddr;
    logic [12:0] oUop;
    logic        oUopValid, oPcInc, oFlagUpdate, oMopDone, oFetchReady, oError;

    logic [12:0] rom   [256];
    logic [7:0]  lut   [256];
    logic [7:0]  cblut [256];

    assign iUop       = rom[oUopAddr];
    assign iFlowIdx   = lut[oLutMop];
    assign iCbFlowIdx = cblut[oLutMop];

    always #5 iClock = ~iClock;

    dzcpu_useq #(.UOP_W(13), .ADDR_W(8)) dut (
        .iClock(iClock), .iReset(iReset), .iMop(iMop), .iMopValid(iMopValid),
        .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx), .iUop(iUop), .iZFlag(iZFlag),
        .iStall(iStall), .oLutMop(oLutMop), .oUopAddr(oUopAddr), .oUop(oUop),
        .oUopValid(oUopValid), .oPcInc(oPcInc), .oFlagUpdate(oFlagUpdate),
        .oMopDone(oMopDone), .oFetchReady(oFetchReady), .oError(oError)
    );

    typedef struct {
        logic [7:0] mop;
        bit mvld, z, stall;
        bit fr, uv, pi, fu, dn, er;
        logic [7:0] addr;
        bit chk_addr, chk_lut;
    } rec_t;

    rec_t trace[$];
    rec_t gen[$];
    int n_chk = 0;
    int n_fail = 0;

    int ldsp_addr [6] = '{1, 2, 3, 3, 3, 4};
    bit ldsp_pi   [6] = '{1, 1, 0, 0, 0, 1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(logic [7:0] mop, bit mvld, bit z, bit stall, bit fr, bit uv,
                                bit pi, bit fu, bit dn, bit er, logic [7:0] addr, bit ca, bit cl);
        rec_t r;
        r.mop = mop; r.mvld = mvld; r.z = z; r.stall = stall;
        r.fr = fr; r.uv = uv; r.pi = pi; r.fu = fu; r.dn = dn; r.er = er;
        r.addr = addr; r.chk_addr = ca; r.chk_lut = cl;
        return r;
    endfunction

    // Walk a macro-op's flow through the ROM, one expectation per clock cycle
    task automatic model_mop(input logic [7:0] mop, input bit z, input logic [7:0] cbmop,
                             input int stall_addr, input int stall_n);
        logic [7:0]  pc;
        logic [12:0] u;
        logic [3:0]  fl;
        int cnt, left;
        bit inc, fu, ends, skip, valid, err, done;
        cnt  = 0;
        left = stall_n;
        gen.push_back(mk(mop, 1, z, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 1));
        pc = lut[mop];
        for (int step = 0; step < 300; step++) begin
            if (int'(pc) == stall_addr) begin
                while (left > 0) begin
                    gen.push_back(mk(8'hFF, 1, z, 1, 0, 0, 0, 0, 0, 0, pc, 1, 0));
                    left--;
                end
            end
            u  = rom[pc];
            fl = u[12:9];
            inc   = fl inside {FLOW_INC, FLOW_INC_EOF, FLOW_INC_EOF_FU, FLOW_INC_EOF_Z, FLOW_INC_EOF_NZ};
            fu    = fl inside {FLOW_UPDATE_FLAGS, FLOW_EOF_FU, FLOW_INC_EOF_FU};
            ends  = fl inside {FLOW_EOF, FLOW_INC_EOF, FLOW_EOF_FU, FLOW_INC_EOF_FU};
            skip  = (fl == FLOW_INC_EOF_Z && z) || (fl == FLOW_INC_EOF_NZ && !z);
            valid = !skip && (fl != FLOW_NOP);
            if (valid) cnt++;
            err  = WDOG && (cnt == 64) && valid && !(ends || skip);
            done = ends || skip || err;
            gen.push_back(mk(8'hFF, 1, z, 0, 0, valid, inc, fu, done, err, pc, 1, 0));
            if (done) break;
            if (u[8:4] == UOP_JCB) begin
                gen.push_back(mk(cbmop, 1, z, 0, 0, 0, 0, 0, 0, 0, pc, 1, 1));
                pc = cblut[cbmop];
            end else begin
                pc = pc + 8'd1;
            end
        end
    endtask

    task automatic commit_gen();
        foreach (gen[i]) trace.push_back(gen[i]);
        gen.delete();
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) trace.push_back(mk(8'h00, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 1));
    endtask

    initial begin
        rec_t r;
        int nv;
        for (int a = 0; a < 256; a++) begin
            rom[a]   = {FLOW_OP, 5'd1, 4'(a)};
            lut[a]   = 8'd0;
            cblut[a] = 8'd0;
        end
        rom[0]  = {FLOW_INC_EOF, 5'd2, 4'h0};
        rom[1]  = {FLOW_INC, 5'd3, 4'h1};
        rom[2]  = {FLOW_INC, 5'd3, 4'h2};
        rom[3]  = {FLOW_OP, 5'd4, 4'h3};
        rom[4]  = {FLOW_INC_EOF, 5'd5, 4'h4};
        rom[13] = {FLOW_OP, 5'd6, 4'h0};
        rom[14] = {FLOW_OP, 5'd7, 4'h1};
        rom[15] = {FLOW_OP, UOP_JCB, 4'h2};
        rom[16] = {FLOW_EOF_FU, 5'd8, 4'h7};
        rom[17] = {FLOW_OP, 5'd9, 4'h0};
        rom[18] = {FLOW_OP, 5'd10, 4'h1};
        rom[19] = {FLOW_INC_EOF_Z, 5'd11, 4'h2};
        rom[20] = {FLOW_OP, 5'd12, 4'h3};
        rom[21] = {FLOW_OP, 5'd13, 4'h4};
        rom[22] = {FLOW_EOF, 5'd14, 4'h5};
        rom[23] = {FLOW_NOP, 5'd15, 4'h0};
        rom[24] = {FLOW_UPDATE_FLAGS, 5'd16, 4'h1};
        rom[25] = {4'hE, 5'd17, 4'h2};
        rom[26] = {FLOW_INC_EOF_NZ, 5'd18, 4'h3};
        rom[27] = {FLOW_INC_EOF_FU, 5'd19, 4'h4};
        lut[MOP_LDSPNN] = 8'd1;
        lut[MOP_CB]     = 8'd13;
        lut[MOP_JRNZ_N] = 8'd17;
        lut[MOP_JRZ_N]  = 8'd23;
        lut[8'h40]      = 8'd100;
        cblut[MOP_BIT7H] = 8'd16;

        // Reset held two cycles
        repeat (2) @(posedge iClock);
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        chk("reset fetch_ready", 32'(oFetchReady), 32'd1);
        chk("reset uop_addr", 32'(oUopAddr), 32'd0);
        chk("reset uop_valid", 32'(oUopValid), 32'd0);
        chk("reset pc_inc", 32'(oPcInc), 32'd0);
        chk("reset error", 32'(oError), 32'd0);

        add_idle(1);
        model_mop(MOP_NOP, 0, 8'h00, -1, 0);
        commit_gen();
        model_mop(MOP_LDSPNN, 0, 8'h00, -1, 0);
        commit_gen();
        model_mop(MOP_LDSPNN, 0, 8'h00, 3, 2);
        chk("model ldsp len", 32'(gen.size()), 32'd7);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("model ldsp addr%0d", i), 32'(gen[i+1].addr), 32'(ldsp_addr[i]));
            chk($sformatf("model ldsp inc%0d", i), 32'(gen[i+1].pi), 32'(ldsp_pi[i]));
        end
        chk("model ldsp done", 32'(gen[6].dn), 32'd1);
        commit_gen();
        model_mop(MOP_JRNZ_N, 1, 8'h00, -1, 0);
        chk("model jrnz z1 len", 32'(gen.size()), 32'd4);
        chk("model jrnz z1 addr", 32'(gen[3].addr), 32'd19);
        chk("model jrnz z1 valid", 32'(gen[3].uv), 32'd0);
        chk("model jrnz z1 inc", 32'(gen[3].pi), 32'd1);
        commit_gen();
        model_mop(MOP_JRNZ_N, 0, 8'h00, -1, 0);
        chk("model jrnz z0 last", 32'(gen[gen.size()-1].addr), 32'd22);
        commit_gen();
        model_mop(MOP_CB, 0, MOP_BIT7H, -1, 0);
        chk("model cb len", 32'(gen.size()), 32'd6);
        chk("model cb last addr", 32'(gen[5].addr), 32'd16);
        chk("model cb last fu", 32'(gen[5].fu), 32'd1);
        commit_gen();
        model_mop(MOP_JRZ_N, 1, 8'h00, -1, 0);
        commit_gen();
        model_mop(MOP_JRZ_N, 0, 8'h00, -1, 0);
        commit_gen();
        model_mop(8'h40, 0, 8'h00, -1, 0);
        nv = 0;
        foreach (gen[i]) if (gen[i].uv) nv++;
        chk("model runaway issues", 32'(nv), WDOG ? 32'd64 : 32'd157);
        chk("model runaway last addr", 32'(gen[gen.size()-1].addr), WDOG ? 32'd163 : 32'd0);
        chk("model runaway error", 32'(gen[gen.size()-1].er), 32'(WDOG));
        commit_gen();
        model_mop(MOP_LDSPNN, 0, 8'h00, -1, 0);
        commit_gen();
        add_idle(2);

        foreach (trace[i]) begin
            r = trace[i];
            @(negedge iClock);
            iMop      = r.mop;
            iMopValid = r.mvld;
            iZFlag    = r.z;
            iStall    = r.stall;
            #1;
            chk($sformatf("cyc%0d fetch_ready", i), 32'(oFetchReady), 32'(r.fr));
            chk($sformatf("cyc%0d uop_valid", i), 32'(oUopValid), 32'(r.uv));
            chk($sformatf("cyc%0d pc_inc", i), 32'(oPcInc), 32'(r.pi));
            chk($sformatf("cyc%0d flag_update", i), 32'(oFlagUpdate), 32'(r.fu));
            chk($sformatf("cyc%0d mop_done", i), 32'(oMopDone), 32'(r.dn));
            chk($sformatf("cyc%0d error", i), 32'(oError), 32'(r.er));
            if (r.chk_addr) begin
                chk($sformatf("cyc%0d uop_addr", i), 32'(oUopAddr), 32'(r.addr));
                chk($sformatf("cyc%0d uop", i), 32'(oUop), 32'(rom[r.addr]));
            end
            if (r.chk_lut) chk($sformatf("cyc%0d lut_mop", i), 32'(oLutMop), 32'(r.mop));
        end

        // Reset in the middle of LDSPnn
        @(negedge iClock);
        iMop = MOP_LDSPNN; iMopValid = 1'b1; iStall = 1'b0;
        @(negedge iClock);
        iMopValid = 1'b0;
        @(negedge iClock);
        #1;
        chk("midreset pre addr", 32'(oUopAddr), 32'd2);
        iReset = 1'b1;
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        chk("midreset fetch_ready", 32'(oFetchReady), 32'd1);
        chk("midreset uop_addr", 32'(oUopAddr), 32'd0);
        chk("midreset uop_valid", 32'(oUopValid), 32'd0);
        chk("midreset pc_inc", 32'(oPcInc), 32'd0);
        chk("midreset mop_done", 32'(oMopDone), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
